wsi_axis_buffer: RTL

WSI_AXIS_BUFFER -- requirements
Module: wsi_axis_buffer

---
 rtl/oped_pkg.sv | 19 +
 rtl/wsi_axis_buffer_ram.sv | 36 +++
 rtl/wsi_axis_buffer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/oped_pkg.sv
// Shared constants and helpers for the WSI/AXI-Stream buffer family.
package oped_pkg;

   localparam int unsigned DATA_W_DEFAULT = 256;

   // STORE_FWD encodings
   localparam int unsigned STORE_FWD_CUT = 0;
   localparam int unsigned STORE_FWD_SAF = 1;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) res = i + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/wsi_axis_buffer_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// Only the read register is reset so the output bus reads zero out of reset.
module wsi_axis_buffer_ram
   import oped_pkg::*;
#(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      wr_en_i,
   input  logic [clog2(Depth)-1:0]   wr_addr_i,
   input  logic [Width-1:0]          wr_data_i,
   input  logic                      rd_en_i,
   input  logic [clog2(Depth)-1:0]   rd_addr_i,
   output logic [Width-1:0]          rd_data_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/wsi_axis_buffer.sv
// Stream buffer with registered output, cut-through or store-and-forward release.
// The RAM read register doubles as the output register; level counts it too.
module wsi_axis_buffer
   import oped_pkg::*;
#(
   parameter int unsigned DATA_W    = DATA_W_DEFAULT,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned STORE_FWD = STORE_FWD_CUT
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    flush,
   input  logic                    s_tvalid,
   output logic                    s_tready,
   input  logic [DATA_W-1:0]       s_tdata,
   input  logic [DATA_W/8-1:0]     s_tstrb,
   input  logic                    s_tlast,
   output logic                    m_tvalid,
   input  logic                    m_tready,
   output logic [DATA_W-1:0]       m_tdata,
   output logic [DATA_W/8-1:0]     m_tstrb,
   output logic                    m_tlast,
   output logic [clog2(DEPTH):0]   level,
   output logic [clog2(DEPTH):0]   msg_count,
   output logic                    full,
   output logic                    empty
);

   localparam int unsigned AW = clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned SW = DATA_W / 8;
   localparam int unsigned RW = DATA_W + SW + 1;
   localparam logic [AW:0] FullLevel = LW'(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d, msg_q, msg_d, pending;
   logic          out_vld_q, out_vld_d, in_msg_q, in_msg_d, rdy_en_q;
   logic          wr, pop, load, gate_open;
   logic [RW-1:0] rd_data;

   always_comb begin
      full      = (level_q == FullLevel);
      empty     = (level_q == '0);
      // rdy_en_q holds s_tready low until the first edge after reset release
      s_tready  = rdy_en_q && !full && !flush;
      gate_open = (STORE_FWD == STORE_FWD_CUT) || (msg_q != '0) || full || in_msg_q;
      m_tvalid  = out_vld_q && gate_open;
      wr        = s_tvalid && s_tready;
      pop       = m_tvalid && m_tready && !flush;
      pending   = level_q - {{AW{1'b0}}, out_vld_q};
      load      = (pending != '0) && (!out_vld_q || pop) && !flush;
   end

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      level_d   = level_q;
      msg_d     = msg_q;
      out_vld_d = out_vld_q;
      in_msg_d  = in_msg_q;
      if (flush) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         level_d   = '0;
         msg_d     = '0;
         out_vld_d = 1'b0;
         in_msg_d  = 1'b0;
      end else begin
         if (wr)   wr_ptr_d = wr_ptr_q + AW'(1);
         if (load) rd_ptr_d = rd_ptr_q + AW'(1);
         level_d = level_q + LW'(wr) - LW'(pop);
         msg_d   = msg_q + LW'(wr && s_tlast) - LW'(pop && m_tlast);
         if (load) begin
            out_vld_d = 1'b1;
         end else if (pop) begin
            out_vld_d = 1'b0;
         end
         // once a message starts leaving it is not gated again until its last beat
         if (pop) in_msg_d = !m_tlast;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         msg_q     <= '0;
         out_vld_q <= 1'b0;
         in_msg_q  <= 1'b0;
         rdy_en_q  <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         msg_q     <= msg_d;
         out_vld_q <= out_vld_d;
         in_msg_q  <= in_msg_d;
         rdy_en_q  <= 1'b1;
      end
   end

   wsi_axis_buffer_ram #(
      .Width (RW),
      .Depth (DEPTH)
   ) u_ram (
      .clk_i     (CLK),
      .rst_ni    (RST_N),
      .wr_en_i   (wr),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i ({s_tdata, s_tstrb, s_tlast}),
      .rd_en_i   (load),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (rd_data)
   );

   assign m_tdata   = rd_data[RW-1 -: DATA_W];
   assign m_tstrb   = rd_data[SW:1];
   assign m_tlast   = rd_data[0];
   assign level     = level_q;
   assign msg_count = msg_q;

endmodule
